// File: rtl/seq_alu.sv
// seq_alu: registered ALU stage with valid/ready handshakes on input and output.
// The iterative shift-add multiplier is built only when SEQ_ALU_MUL_EN is defined.
module seq_alu #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [2:0]       op_select,
   input  logic             be_select,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             e,
   output logic             z,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   localparam logic [0:0] ST_IDLE = 1'b0;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [0:0] ST_MUL  = 1'b1;
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
`endif
   localparam logic [SHW-1:0] SH_LIM = SHW'(WIDTH);

   logic [0:0]       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             e_q, e_d;
   logic             z_q, z_d;

`ifdef SEQ_ALU_MUL_EN
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic             e_mul_q, e_mul_d;
   logic [WIDTH:0]   step_sum_s;
   logic [WIDTH-1:0] hi_nxt_s;
   logic [WIDTH-1:0] lo_nxt_s;
`endif

   logic             in_ready_s;
   logic             accept_s;
   logic             eq_s;
   logic [SHW-1:0]   sh_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] alu_s;
   logic             alu_cout_s;

   assign in_ready_s = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
   assign accept_s   = in_valid && in_ready_s;
   assign eq_s       = be_select ? (i0 != i1) : (i0 == i1);
   assign sh_s       = i1[SHW-1:0];
   assign sum_s      = {1'b0, i0} + {1'b0, i1};

   // Single-cycle operations; mul is handled by the sequencer, so it yields zero here.
   always_comb begin
      alu_s      = {WIDTH{1'b0}};
      alu_cout_s = 1'b0;
      case (op_select)
         OP_ADD: begin
            alu_s      = sum_s[WIDTH-1:0];
            alu_cout_s = sum_s[WIDTH];
         end
         OP_SUB: begin
            alu_s      = i0 - i1;
            alu_cout_s = (i0 < i1);
         end
         OP_AND: alu_s = i0 & i1;
         OP_OR:  alu_s = i0 | i1;
         OP_XOR: alu_s = i0 ^ i1;
         OP_MUL: alu_s = {WIDTH{1'b0}};
         OP_SHL: begin
            if (sh_s >= SH_LIM) alu_s = {WIDTH{1'b0}};
            else                alu_s = i0 << sh_s;
         end
         OP_SHR: begin
            if (sh_s >= SH_LIM) alu_s = {WIDTH{1'b0}};
            else                alu_s = i0 >> sh_s;
         end
         default: begin
            alu_s      = {WIDTH{1'b0}};
            alu_cout_s = 1'b0;
         end
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   // One shift-add step: {hi,lo} shifts right while lo drains the multiplier bits.
   always_comb begin
      if (lo_q[0]) step_sum_s = {1'b0, hi_q} + {1'b0, mcand_q};
      else         step_sum_s = {1'b0, hi_q};
      hi_nxt_s = step_sum_s[WIDTH:1];
      lo_nxt_s = {step_sum_s[0], lo_q[WIDTH-1:1]};
   end
`endif

   // Next-state, result register and multiplier sequencing.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      s_d         = s_q;
      cout_d      = cout_q;
      e_d         = e_q;
      z_d         = z_q;
`ifdef SEQ_ALU_MUL_EN
      mcand_d     = mcand_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      cnt_d       = cnt_q;
      e_mul_d     = e_mul_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
`ifdef SEQ_ALU_MUL_EN
               if (op_select == OP_MUL) begin
                  state_d     = ST_MUL;
                  out_valid_d = 1'b0;
                  mcand_d     = i0;
                  hi_d        = {WIDTH{1'b0}};
                  lo_d        = i1;
                  cnt_d       = {SHW{1'b0}};
                  e_mul_d     = eq_s;
               end else begin
`else
               begin
`endif
                  out_valid_d = 1'b1;
                  s_d         = alu_s;
                  cout_d      = alu_cout_s;
                  e_d         = eq_s;
                  z_d         = (alu_s == {WIDTH{1'b0}});
               end
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
            end else begin
               out_valid_d = out_valid_q;
            end
         end
`ifdef SEQ_ALU_MUL_EN
         ST_MUL: begin
            hi_d  = hi_nxt_s;
            lo_d  = lo_nxt_s;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b1;
               s_d         = lo_nxt_s;
               cout_d      = |hi_nxt_s;
               e_d         = e_mul_q;
               z_d         = (lo_nxt_s == {WIDTH{1'b0}});
            end else begin
               state_d = ST_MUL;
            end
         end
`endif
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any multiply in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         s_q         <= {WIDTH{1'b0}};
         cout_q      <= 1'b0;
         e_q         <= 1'b0;
         z_q         <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         mcand_q     <= {WIDTH{1'b0}};
         hi_q        <= {WIDTH{1'b0}};
         lo_q        <= {WIDTH{1'b0}};
         cnt_q       <= {SHW{1'b0}};
         e_mul_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         cout_q      <= cout_d;
         e_q         <= e_d;
         z_q         <= z_d;
`ifdef SEQ_ALU_MUL_EN
         mcand_q     <= mcand_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         cnt_q       <= cnt_d;
         e_mul_q     <= e_mul_d;
`endif
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign cout      = cout_q;
   assign e         = e_q;
   assign z         = z_q;
`ifdef SEQ_ALU_MUL_EN
   assign busy      = (state_q == ST_MUL);
`else
   assign busy      = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Testbench for seq_alu: table-driven vectors through a result scoreboard, plus
// hand sequences for backpressure, multiply latency and reset during multiply.
module tb_seq_alu;

   typedef struct {
      logic [2:0]  op;
      logic [19:0] a;
      logic [19:0] b;
      logic        be;
      logic [19:0] s;
      logic        c;
      logic        e;
      logic        z;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] i0;
   logic [19:0] i1;
   logic [2:0]  op_select;
   logic        be_select;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] s;
   logic        cout;
   logic        e;
   logic        z;
   logic        busy;

   int   total = 0;
   int   bad   = 0;
   vec_t exp_q[$];
   vec_t mon_v;
   vec_t tbl[14];

   seq_alu #(.WIDTH(20)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .i0(i0), .i1(i1), .op_select(op_select), .be_select(be_select),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout),
      .e(e), .z(z), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // scoreboard: every transfer on the output side is compared with the oldest expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got s=%h with no expectation queued", s);
         end else begin
            mon_v = exp_q.pop_front();
            check($sformatf("result op=%0d a=%h b=%h", mon_v.op, mon_v.a, mon_v.b),
                  {9'd0, s, cout, e, z}, {9'd0, mon_v.s, mon_v.c, mon_v.e, mon_v.z});
         end
      end
   end

   task automatic send(input vec_t v, output int waits);
      i0 = v.a; i1 = v.b; op_select = v.op; be_select = v.be; in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 64) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready stayed 0 for op=%0d", v.op);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         exp_q.push_back(v);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int   w;
      int   nb;
      int   lat;
      bit   seen;
      vec_t v;

      // op, a, b, be, expected s, cout, e, z
      tbl[0]  = '{3'b000, 20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{3'b001, 20'h00005, 20'h00007, 1'b1, 20'hFFFFE, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{3'b110, 20'h00001, 20'h00013, 1'b0, 20'h80000, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{3'b110, 20'h00001, 20'h00014, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{3'b111, 20'h80000, 20'h00013, 1'b0, 20'h00001, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{3'b010, 20'h0F0F0, 20'h0FF00, 1'b0, 20'h0F000, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{3'b011, 20'h0F0F0, 20'h0FF00, 1'b1, 20'h0FFF0, 1'b0, 1'b1, 1'b0};
      tbl[7]  = '{3'b100, 20'h12345, 20'h12345, 1'b0, 20'h00000, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{3'b000, 20'h12345, 20'h54321, 1'b0, 20'h66666, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{3'b001, 20'h00007, 20'h00007, 1'b1, 20'h00000, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{3'b111, 20'hFFFFF, 20'h0003F, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{3'b110, 20'hFFFFF, 20'h00040, 1'b0, 20'hFFFFF, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{3'b001, 20'h00000, 20'h00001, 1'b0, 20'hFFFFF, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{3'b000, 20'h80000, 20'h80000, 1'b1, 20'h00000, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; i0 = 20'h0; i1 = 20'h0;
      op_select = 3'b000; be_select = 1'b0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_s_flags", {9'd0, s, cout, e, z}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      idle(2);

      // back-to-back stream: in_ready must never drop
      for (int k = 0; k < 14; k++) begin
         send(tbl[k], w);
         check($sformatf("stream_wait_%0d", k), w, 32'd0);
      end
      idle(3);

      // backpressure hold, then release with a new op pending
      out_ready = 1'b0;
      v = '{3'b100, 20'hA5A5A, 20'h5A5A5, 1'b1, 20'hFFFFF, 1'b0, 1'b1, 1'b0};
      send(v, w);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check("hold_result", {9'd0, s, cout, e, z}, {9'd0, 20'hFFFFF, 1'b0, 1'b1, 1'b0});
         check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      v = '{3'b000, 20'h00001, 20'h00001, 1'b0, 20'h00002, 1'b0, 1'b1, 1'b0};
      send(v, w);
      check("release_wait", w, 32'd0);
      @(negedge clk);
      check("no_bubble", {31'd0, out_valid}, 32'd1);
      idle(3);

      // multiply latency and busy duration
`ifdef SEQ_ALU_MUL_EN
      v = '{3'b101, 20'h00400, 20'h00400, 1'b0, 20'h00000, 1'b1, 1'b1, 1'b1};
`else
      v = '{3'b101, 20'h00400, 20'h00400, 1'b0, 20'h00000, 1'b0, 1'b1, 1'b1};
`endif
      send(v, w);
      nb = 0; lat = 0; seen = 1'b0;
      for (int k = 1; k <= 60 && !seen; k++) begin
         @(negedge clk);
         if (busy) nb++;
         if (out_valid) begin
            seen = 1'b1;
            lat  = k;
         end
      end
`ifdef SEQ_ALU_MUL_EN
      check("mul_busy_cycles", nb, 32'd20);
      check("mul_latency", lat, 32'd21);
      v = '{3'b101, 20'hFFFFF, 20'hFFFFF, 1'b1, 20'h00001, 1'b1, 1'b0, 1'b0};
`else
      check("mul_busy_cycles", nb, 32'd0);
      check("mul_latency", lat, 32'd1);
      v = '{3'b101, 20'hFFFFF, 20'hFFFFF, 1'b1, 20'h00000, 1'b0, 1'b0, 1'b1};
`endif
      @(posedge clk);
      #1;
      send(v, w);
      idle(25);

      // reset during the fifth multiply cycle
`ifdef SEQ_ALU_MUL_EN
      v = '{3'b101, 20'h00003, 20'h00005, 1'b0, 20'h0000F, 1'b0, 1'b0, 1'b0};
`else
      v = '{3'b101, 20'h00003, 20'h00005, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b1};
`endif
      send(v, w);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_s_flags", {9'd0, s, cout, e, z}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
         check("post_reset_no_stale", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      v = '{3'b000, 20'h00002, 20'h00002, 1'b0, 20'h00004, 1'b0, 1'b1, 1'b0};
      send(v, w);
      idle(4);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
